// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
//   Shared definitions for the pipeline hazard/stall controller:
//   FSM state encoding, MAX_WAIT default, the packed bundle of
//   pipeline-register control strobes and the RUN-mode rule function.
package pipeline_ctrl_pkg;

    localparam int MAX_WAIT_DEFAULT = 15;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    // Bit order matches the output order used by the top level.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } ctrl_t;

    // Everything advances, nothing is squashed.
    localparam ctrl_t CTRL_RUN    = ctrl_t'(8'b1111_0000);
    // Whole front of the pipe frozen; the bubble goes into MEM/WB.
    localparam ctrl_t CTRL_FROZEN = ctrl_t'(8'b0000_0001);
    // Dead pipe: nothing moves and nothing is flushed.
    localparam ctrl_t CTRL_IDLE   = ctrl_t'(8'b0000_0000);
    // While reset is held every stage is squashed.
    localparam ctrl_t CTRL_RESET  = ctrl_t'(8'b0000_1111);

    // Normal-flow rules: a taken branch squashes the three younger stages
    // and wins over a load-use stall, since the stalled instruction is
    // on the wrong path anyway.
    function automatic ctrl_t run_rules(input logic load_use, input logic branch);
        ctrl_t c;
        c = CTRL_RUN;
        if (branch) begin
            c.if_id_flush  = 1'b1;
            c.id_ex_flush  = 1'b1;
            c.ex_mem_flush = 1'b1;
        end else if (load_use) begin
            c.pc_write    = 1'b0;
            c.if_id_write = 1'b0;
            c.id_ex_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_controller_hazard_detect.sv
// hazard_detect
//   Combinational load-use detector: a load in ID/EX whose destination
//   is read by the instruction in ID.
//   id_rs1, id_rs2 : source registers of the instruction in ID
//   ex_rd          : destination register of the instruction in ID/EX
//   ex_mem_read    : ID/EX holds a load
//   load_use       : stall required this cycle
module hazard_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       load_use
);

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller
//   Stall/flush controller for a 5-stage pipeline: load-use stalls,
//   taken-branch flushes, data-memory wait freezing with a timeout
//   into a sticky error state, and a saturating stall-cycle counter.
//   clk, reset (async, active-low)
//   id_rs1, id_rs2, ex_rd, ex_mem_read : load-use detection inputs
//   branch_taken                       : EX/MEM branch resolved taken
//   mem_req, mem_ready                 : data-memory handshake
//   pc_write .. mem_wb_flush           : pipeline register strobes
//   mem_error                          : sticky timeout flag
//   stall_cycles                       : cycles with pc_write low
//   state                              : current FSM state
module pipeline_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_write,
    output logic        id_ex_flush,
    output logic        ex_mem_write,
    output logic        ex_mem_flush,
    output logic        mem_wb_flush,
    output logic        mem_error,
    output logic [15:0] stall_cycles,
    output logic [1:0]  state
);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt, wait_d;
    logic       load_use;
    ctrl_t      ctrl;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    always_comb begin
        // NOTE: every output of this block is defaulted first so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        wait_d  = wait_cnt;
        ctrl    = CTRL_IDLE;

        case (state_q)
            RUN: begin
                // A stalled memory access outranks everything: the branch
                // sitting in EX/MEM is frozen and re-evaluated on release.
                if (mem_req && !mem_ready) begin
                    ctrl    = CTRL_FROZEN;
                    state_d = MEM_WAIT;
                    wait_d  = 8'd1;
                end else begin
                    ctrl = run_rules(load_use, branch_taken);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    ctrl    = run_rules(load_use, branch_taken);
                    state_d = RUN;
                    wait_d  = 8'd0;
                end else begin
                    ctrl = CTRL_FROZEN;
                    if (wait_cnt == 8'(MAX_WAIT)) begin
                        state_d = ERROR;
                    end else begin
                        wait_d = wait_cnt + 8'd1;
                    end
                end
            end
            ERROR: begin
                ctrl    = CTRL_IDLE;
                state_d = ERROR;
            end
            default: begin
                ctrl    = CTRL_IDLE;
                state_d = RUN;
                wait_d  = 8'd0;
            end
        endcase

        // Reset squashes every stage regardless of the current state.
        if (!reset) begin
            ctrl = CTRL_RESET;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples its pre-edge inputs, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            wait_cnt <= 8'd0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= wait_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= 16'd0;
            mem_error    <= 1'b0;
        end else begin
            if (!ctrl.pc_write && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (state_d == ERROR) begin
                mem_error <= 1'b1;
            end
        end
    end

    assign {pc_write, if_id_write, id_ex_write, ex_mem_write,
            if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = ctrl;
    assign state = state_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller
//   Directed scenarios with constant expectations plus a randomized run
//   compared against a cycle-level behavioural model of the controller.
`timescale 1ns/1ps
module tb_pipeline_controller;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic        ex_mem_read = 1'b0, branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b1;
    logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
    logic        ex_mem_write, ex_mem_flush, mem_wb_flush, mem_error;
    logic [15:0] stall_cycles;
    logic [1:0]  state;

    always #5 clk = ~clk;

    pipeline_controller #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .id_ex_write  (id_ex_write),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_write (ex_mem_write),
        .ex_mem_flush (ex_mem_flush),
        .mem_wb_flush (mem_wb_flush),
        .mem_error    (mem_error),
        .stall_cycles (stall_cycles),
        .state        (state)
    );

    // {pc_write, if_id_write, id_ex_write, ex_mem_write,
    //  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}
    logic [7:0] ctrl_now;
    assign ctrl_now = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

    int checks = 0;
    int passed = 0;

    // Behavioural model: "waited" counts consecutive frozen cycles of the
    // current memory access; exceeding MAX_WAIT of them kills the pipe.
    bit m_err = 1'b0;
    int m_waited = 0;
    int m_stalls = 0;

    logic [7:0]  exp_ctrl, obs_ctrl;
    logic [1:0]  exp_state, obs_state, obs_pre;
    logic [15:0] exp_stall, obs_stall;
    logic        exp_err, obs_err;

    task automatic drive_random();
        id_rs1       = 5'($urandom_range(0, 3));
        id_rs2       = 5'($urandom_range(0, 3));
        ex_rd        = 5'($urandom_range(0, 3));
        ex_mem_read  = 1'($urandom_range(0, 1));
        branch_taken = ($urandom_range(0, 4) == 0);
        mem_req      = 1'($urandom_range(0, 1));
        mem_ready    = ($urandom_range(0, 9) < 7);
    endtask

    task automatic reset_low();
        @(negedge clk);
        #2;
        drive_random();
        reset = 1'b0;
        m_err = 1'b0;
        m_waited = 0;
        m_stalls = 0;
    endtask

    task automatic reset_release();
        @(negedge clk);
        reset = 1'b1;
        {id_rs1, id_rs2, ex_rd} = '0;
        {ex_mem_read, branch_taken, mem_req} = '0;
        mem_ready = 1'b1;
    endtask

    task automatic do_reset();
        reset_low();
        reset_release();
    endtask

    // One clock cycle: drive, sample combinational outputs, clock, sample
    // registered outputs; the model produces the matching expectations.
    task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic mrd, input logic br, input logic mreq, input logic mrdy);
        bit lu, frozen;
        @(negedge clk);
        id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
        ex_mem_read = mrd; branch_taken = br; mem_req = mreq; mem_ready = mrdy;
        #1;
        lu = mrd && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
        frozen = 1'b0;
        if (m_err) begin
            exp_ctrl = 8'b0000_0000;
        end else begin
            frozen = (m_waited > 0) ? !mrdy : (mreq && !mrdy);
            if (frozen)  exp_ctrl = 8'b0000_0001;
            else if (br) exp_ctrl = 8'b1111_1110;
            else if (lu) exp_ctrl = 8'b0011_0100;
            else         exp_ctrl = 8'b1111_0000;
        end
        obs_ctrl = ctrl_now;
        obs_pre  = state;
        @(posedge clk);
        if (!m_err) begin
            if (frozen) begin
                m_waited++;
                if (m_waited > MAX_WAIT) m_err = 1'b1;
            end else begin
                m_waited = 0;
            end
        end
        if (!exp_ctrl[7] && m_stalls < 65535) m_stalls++;
        #1;
        exp_state = m_err ? 2'd2 : ((m_waited > 0) ? 2'd1 : 2'd0);
        exp_stall = 16'(m_stalls);
        exp_err   = m_err;
        obs_state = state;
        obs_stall = stall_cycles;
        obs_err   = mem_error;
    endtask

    task automatic test_reset();
        reset_low();
        #1;
        checks++; if (ctrl_now !== 8'b0000_1111) $display("FAIL reset_ctrl: got %b want 00001111", ctrl_now); else passed++;
        checks++; if (state !== 2'd0) $display("FAIL reset_state: got %0d want 0", state); else passed++;
        checks++; if (stall_cycles !== 16'd0) $display("FAIL reset_stall: got %0d want 0", stall_cycles); else passed++;
        checks++; if (mem_error !== 1'b0) $display("FAIL reset_err: got %b want 0", mem_error); else passed++;
        reset_release();
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (obs_ctrl !== 8'b1111_0000) $display("FAIL run_default: got %b want 11110000", obs_ctrl); else passed++;
    endtask

    task automatic test_load_use();
        do_reset();
        step(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if (obs_ctrl !== 8'b0011_0100) $display("FAIL load_use_ctrl: got %b want 00110100", obs_ctrl); else passed++;
        checks++; if (obs_stall !== 16'd1) $display("FAIL load_use_stall: got %0d want 1", obs_stall); else passed++;
        checks++; if (obs_state !== 2'd0) $display("FAIL load_use_state: got %0d want 0", obs_state); else passed++;
        step(5'd1, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (obs_ctrl !== 8'b1111_0000) $display("FAIL load_use_release: got %b want 11110000", obs_ctrl); else passed++;
        step(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if (obs_ctrl !== 8'b1111_0000) $display("FAIL load_use_x0: got %b want 11110000", obs_ctrl); else passed++;
        checks++; if (obs_stall !== 16'd1) $display("FAIL load_use_x0_stall: got %0d want 1", obs_stall); else passed++;
    endtask

    task automatic test_branch_load_use();
        do_reset();
        step(5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        checks++; if (obs_ctrl !== 8'b1111_1110) $display("FAIL branch_lu_ctrl: got %b want 11111110", obs_ctrl); else passed++;
        checks++; if (obs_stall !== 16'd0) $display("FAIL branch_lu_stall: got %0d want 0", obs_stall); else passed++;
    endtask

    task automatic test_mem_wait();
        logic [1:0] pre[4]  = '{2'd0, 2'd1, 2'd1, 2'd1};
        logic [1:0] post[4] = '{2'd1, 2'd1, 2'd1, 2'd0};
        logic [7:0] c[4]    = '{8'h01, 8'h01, 8'h01, 8'hF0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, (i == 3));
            checks++; if (obs_ctrl !== c[i]) $display("FAIL mem_wait_ctrl[%0d]: got %b want %b", i, obs_ctrl, c[i]); else passed++;
            checks++; if (obs_pre !== pre[i]) $display("FAIL mem_wait_pre[%0d]: got %0d want %0d", i, obs_pre, pre[i]); else passed++;
            checks++; if (obs_state !== post[i]) $display("FAIL mem_wait_post[%0d]: got %0d want %0d", i, obs_state, post[i]); else passed++;
        end
        checks++; if (obs_stall !== 16'd3) $display("FAIL mem_wait_stall: got %0d want 3", obs_stall); else passed++;
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (i == 3) begin
                checks++; if (obs_state !== 2'd1) $display("FAIL timeout_early: got %0d want 1", obs_state); else passed++;
            end
        end
        checks++; if (obs_state !== 2'd2) $display("FAIL timeout_state: got %0d want 2", obs_state); else passed++;
        checks++; if (obs_err !== 1'b1) $display("FAIL timeout_err: got %b want 1", obs_err); else passed++;
        for (int i = 0; i < 3; i++) begin
            step(5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
            checks++; if (obs_ctrl !== 8'b0000_0000) $display("FAIL error_ctrl[%0d]: got %b want 00000000", i, obs_ctrl); else passed++;
            checks++; if (obs_err !== 1'b1 || obs_state !== 2'd2) $display("FAIL error_sticky[%0d]: got err=%b state=%0d want err=1 state=2", i, obs_err, obs_state); else passed++;
        end
        checks++; if (obs_stall !== 16'd8) $display("FAIL error_stall: got %0d want 8", obs_stall); else passed++;
        do_reset();
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (obs_err !== 1'b0 || obs_state !== 2'd0) $display("FAIL error_cleared: got err=%b state=%0d want err=0 state=0", obs_err, obs_state); else passed++;
    endtask

    task automatic test_deferred_branch();
        logic [7:0] c[3] = '{8'h01, 8'h01, 8'hFE};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, (i == 2));
            checks++; if (obs_ctrl !== c[i]) $display("FAIL deferred_branch[%0d]: got %b want %b", i, obs_ctrl, c[i]); else passed++;
        end
        checks++; if (obs_state !== 2'd0 || obs_stall !== 16'd2) $display("FAIL deferred_end: got state=%0d stall=%0d want state=0 stall=2", obs_state, obs_stall); else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        reset_low();
        #1;
        checks++; if (state !== 2'd0) $display("FAIL async_state: got %0d want 0", state); else passed++;
        checks++; if (ctrl_now !== 8'b0000_1111) $display("FAIL async_ctrl: got %b want 00001111", ctrl_now); else passed++;
        reset_release();
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (obs_ctrl !== 8'b1111_0000 || obs_state !== 2'd0) $display("FAIL async_after: got ctrl=%b state=%0d want 11110000/0", obs_ctrl, obs_state); else passed++;
        // A fresh wait must get the full timeout budget again.
        for (int i = 0; i < 4; i++) step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (obs_state !== 2'd1) $display("FAIL async_no_residue: got %0d want 1", obs_state); else passed++;
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        int err_age;
        do_reset();
        err_age = 0;
        for (int i = 0; i < 1500; i++) begin
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6));
            checks++; if (obs_ctrl !== exp_ctrl) $display("FAIL rand_ctrl[%0d]: got %b want %b", i, obs_ctrl, exp_ctrl); else passed++;
            checks++; if (obs_state !== exp_state) $display("FAIL rand_state[%0d]: got %0d want %0d", i, obs_state, exp_state); else passed++;
            checks++; if (obs_stall !== exp_stall) $display("FAIL rand_stall[%0d]: got %0d want %0d", i, obs_stall, exp_stall); else passed++;
            checks++; if (obs_err !== exp_err) $display("FAIL rand_err[%0d]: got %b want %b", i, obs_err, exp_err); else passed++;
            err_age = m_err ? err_age + 1 : 0;
            if (err_age > 3 || $urandom_range(0, 199) == 0) begin
                do_reset();
                err_age = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_load_use();
        test_mem_wait();
        test_timeout();
        test_deferred_branch();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, meaning the maximum number of data-memory wait cycles tolerated before an error is flagged (range 1..255).
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk in 1, rising-edge clock; reset in 1, asynchronous active-low reset.
REQ-003 SHALL have inputs: id_rs1 5, ID source reg 1; id_rs2 5, ID source reg 2; ex_rd 5, ID/EX dest reg; ex_mem_read 1, ID/EX holds a load; branch_taken 1, EX/MEM branch resolved taken; mem_req 1, EX/MEM instruction accesses data memory; mem_ready 1, data memory completes this cycle.
REQ-004 SHALL have outputs: pc_write 1; if_id_write 1; if_id_flush 1; id_ex_write 1; id_ex_flush 1; ex_mem_write 1; ex_mem_flush 1; mem_wb_flush 1; mem_error 1, sticky; stall_cycles 16, performance count; state 2, current FSM state.

Function
REQ-005 SHALL implement FSM states RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2; 2'd3 is unused and SHALL go to RUN.
REQ-006 SHALL use this default in RUN with no event: all *_write=1 and all *_flush=0.
REQ-007 SHALL detect load-use as ex_mem_read=1, ex_rd!=0, and (ex_rd==id_rs1 or ex_rd==id_rs2).
REQ-008 SHALL handle load-use in RUN in the same cycle, combinationally: pc_write=0, if_id_write=0, id_ex_flush=1, other outputs default; the state stays RUN and the stall lasts exactly one cycle per detection.
REQ-009 SHALL handle branch_taken=1 in RUN, when no memory wait occurs, in the same cycle: if_id_flush=id_ex_flush=ex_mem_flush=1, pc_write=1; it overrides load-use.
REQ-010 SHALL treat mem_req=1 and mem_ready=0 in RUN as a memory wait: freeze pc_write, if_id_write, id_ex_write and ex_mem_write =0 and set mem_wb_flush=1; all other flushes =0; next state MEM_WAIT; wait_cnt loads 1.
REQ-011 SHALL give the memory wait priority over branch_taken and load-use; the branch in frozen EX/MEM is re-evaluated on the release cycle.
REQ-012 SHALL keep the REQ-010 freeze in MEM_WAIT while mem_ready=0 and increment wait_cnt each cycle.
REQ-013 SHALL, in MEM_WAIT with mem_ready=1, apply the RUN rules REQ-006..REQ-009 combinationally that cycle, excluding REQ-010, and then go to RUN with wait_cnt cleared.
REQ-014 SHALL, in MEM_WAIT with mem_ready=0 and wait_cnt==MAX_WAIT, go to ERROR at the next edge.
REQ-015 SHALL, in ERROR, assert mem_error=1 and hold all *_write=0 and all *_flush=0; ERROR is left only by reset, and mem_ready is ignored there.
REQ-016 SHALL increment stall_cycles at each clk edge where pc_write=0, saturating at 16'hFFFF with no wrap.
REQ-017 SHALL use an internal wait_cnt of 8 bits with a compare exactly equal to MAX_WAIT.

Reset
REQ-018 SHALL, on reset low, asynchronously clear state to RUN, wait_cnt to 0, stall_cycles to 0 and mem_error to 0.
REQ-019 SHALL, while reset is low, force all *_write=0 and all *_flush=1 regardless of the inputs.
REQ-020 SHALL, on reset asserted mid-MEM_WAIT or in ERROR, return to RUN at the first clk edge after release with no residual wait count.

Structure
REQ-021 SHALL place the state encodings and the MAX_WAIT default in the shared package pipeline_ctrl_pkg.
REQ-022 SHALL put the load-use comparison (REQ-007) in a combinational sub-module hazard_detect, instantiated once.

Verification
REQ-023 SHALL cover load-use: ex_mem_read=1, ex_rd=5, id_rs2=5 in RUN -> pc_write=0, if_id_write=0, id_ex_flush=1 for one cycle; stall_cycles 0->1; and with ex_rd=0 -> no stall.
REQ-024 SHALL cover branch with load-use: branch_taken=1 and a load-use hit in the same cycle -> if_id_flush=id_ex_flush=ex_mem_flush=1, pc_write=1, stall_cycles unchanged.
REQ-025 SHALL cover a 3-cycle memory wait: mem_req=1, mem_ready low 3 cycles then high -> state 0,1,1,1->0; writes frozen and mem_wb_flush=1 for the 3 cycles; stall_cycles=3.
REQ-026 SHALL cover timeout: MAX_WAIT=4, mem_ready held 0 -> ERROR after the 4th MEM_WAIT cycle, mem_error=1 stays high after mem_ready=1, cleared only by a reset pulse.
REQ-027 SHALL cover deferred branch: branch_taken=1 during a 2-cycle wait -> no flushes while frozen; flushes assert on the mem_ready cycle.
REQ-028 SHALL cover asynchronous reset: reset low mid-MEM_WAIT between clk edges -> state=0 and flushes=1 immediately; normal RUN defaults on the first edge after release.
